wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back end of the register-file interface: drives the decode stage's write port
//  (busW/rw/RegWr), the byte-load controls (LB/LBU/Addr) and the HI/LO update
//  (mult/mult_result).
//  Holds the MEM/WB pipeline register and an iterative 32x32 signed multiplier that EX
//  starts and WB retires.
//  Sits between the memory stage and the decode stage's register file.
// PARAMETERS
//  MUL_CYCLES  32  shift-add iterations; fixed at 32 for 32-bit operands.
// PORTS
//  clk            in   1   single clock; everything is on the rising edge
//  rst            in   1   synchronous reset, active-high
//  stall          in   1   hold the MEM/WB register (hazard unit)
//  flush          in   1   load a bubble into MEM/WB (exception/eret)
//  mem_valid      in   1   MEM stage holds a real instruction
//  mem_RegWr      in   1   instruction writes a GPR
//  mem_rw         in   5   destination GPR
//  mem_MemtoReg   in   1   1: write data is mem_rdata; 0: write data is mem_alu_out
//  mem_alu_out    in   32  ALU result; also the byte address for loads
//  mem_rdata      in   32  full word read from data memory
//  mem_LB         in   1   load byte, signed
//  mem_LBU        in   1   load byte, unsigned
//  ex_mult_start  in   1   start a multiply (EX stage, one-cycle pulse)
//  ex_op_a        in   32  multiplicand (signed)
//  ex_op_b        in   32  multiplier (signed)
//  mult_cancel    in   1   abort an in-flight multiply (its instruction was flushed)
//  busW           out  32  register write data
//  rw             out  5   register write index
//  RegWr          out  1   register write enable
//  LB             out  1   byte-merge control, to the register file
//  LBU            out  1   byte-merge control, to the register file
//  Addr           out  32  load address, to the register file
//  mult           out  1   HI/LO write strobe; one-cycle pulse
//  mult_result    out  64  {HI,LO} product
//  mult_busy      out  1   multiplier occupied; the hazard unit stalls mfhi/mflo/mult
// BEHAVIOUR
//  Reset: all outputs are 0, MEM/WB holds a bubble, multiplier is in IDLE.
//  MEM/WB register, priority rst > flush > stall > load:
//   - flush: next cycle RegWr=0, LB=0, LBU=0; rw, busW and Addr are don't-care.
//   - stall: every output holds its value.
//   - load: one cycle after MEM.
//     - busW = MemtoReg ? rdata : alu_out.
//     - RegWr = valid & mem_RegWr & (mem_rw != 0).
//     - LB/LBU = valid & mem_LB / valid & mem_LBU.
//     - Addr = alu_out.
//   - Writes to $0 are suppressed here; busW still carries the value.
//   - This block carries the full word on busW; byte selection (big-endian, Addr[1:0]=0
//     selects bits 31:24) and extension are done by the register file using LB/LBU/Addr.
//   - mem_LB and mem_LBU both high is illegal; both are forwarded unchanged.
//  Multiplier FSM:
//   - IDLE: ex_mult_start -> RUN.
//     - Latch |a| and |b| and sign = a[31]^b[31]; count = 0.
//     - mult_busy rises in the same cycle as the start is sampled (registered, visible
//       from the next edge).
//   - RUN: one shift-add step per cycle; count increments.
//     - After the 32nd step -> FIX.
//     - mult_busy = 1 throughout RUN and FIX.
//   - FIX: negate the 64-bit product if sign=1 -> DONE.
//   - DONE: one cycle; mult = 1 and mult_result is valid -> IDLE.
//     - mult_result holds until the next DONE.
//   - Latency: start sampled at edge 0; mult pulses in the cycle after edge 34. The
//     cycle count is fixed regardless of operand values.
//   - ex_mult_start while busy is ignored; the hazard unit must not issue it.
//   - mult_cancel in RUN or FIX -> IDLE at the next edge. No mult pulse;
//     mult_result unchanged.
//   - mult_cancel and start in the same cycle while IDLE: cancel wins, the start is
//     dropped.
//   - The multiplier ignores stall and flush; only rst and mult_cancel abort it.
//   - Edge cases: -2^31 * -2^31 = 64'h4000_0000_0000_0000. |-2^31| is held in 33 bits.
//  A DONE pulse and a GPR write in the same cycle are independent; both occur.
// STRUCTURE
//  Shared package: mul_state_e {IDLE,RUN,FIX,DONE} and the width constants
//  REG_W=32, REG_IDX_W=5.
//  Sub-module seq_multiplier: the FSM plus datapath (start/cancel/busy/done/result).
//  wb_stage instantiates it beside the MEM/WB register.
// TESTING
//  1. rst for 2 cycles -> all outputs 0; mult_busy=0.
//  2. ALU write, mem_rw=8, alu_out=32'h1234, MemtoReg=0 -> next cycle RegWr=1, rw=8,
//     busW=32'h1234. Same with mem_rw=0 -> RegWr=0.
//  3. LB, rdata=32'h80FF_0011, alu_out=32'h101 -> next cycle LB=1, Addr=32'h101,
//     busW=32'h80FF_0011. Then stall 3 cycles -> values held. Then flush -> RegWr=0, LB=0.
//  4. start with a=-3, b=7 -> mult_busy for 34 cycles; mult pulses once,
//     mult_result=64'hFFFF_FFFF_FFFF_FFEB.
//  5. start with a=b=32'h8000_0000 -> 64'h4000_0000_0000_0000.
//     Then a=b=32'hFFFF_FFFF -> 64'h1.
//  6. start, then mult_cancel at step 10 -> no mult pulse, mult_busy=0 next cycle,
//     mult_result unchanged. A new start immediately after completes normally.
//     rst asserted mid-RUN -> IDLE.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and widths for the write-back stage and its iterative multiplier.
package wb_stage_pkg;

    localparam int unsigned REG_W     = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned MUL_W     = 2 * REG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    typedef struct packed {
        logic                 regwr;
        logic [REG_IDX_W-1:0] rw;
        logic [REG_W-1:0]     busw;
        logic                 lb;
        logic                 lbu;
        logic [REG_W-1:0]     addr;
    } memwb_t;

endpackage

// File: rtl/wb_stage_seq_multiplier.sv
// Iterative 32x32 signed multiplier: sign-magnitude shift-add, one step per cycle,
// then a sign fix-up; busy/done/result are registered.
module seq_multiplier
    import wb_stage_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic [REG_W-1:0] op_a_i,
    input  logic [REG_W-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [MUL_W-1:0] result_o
);

    localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

    mul_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q;
    logic [MUL_W-1:0] acc_q;
    logic [MUL_W-1:0] mcand_q;
    logic [REG_W:0]   mplier_q;
    logic             busy_q;
    logic             done_q;
    logic [MUL_W-1:0] result_q;

    // Magnitudes need 33 bits so that |-2^31| is representable.
    logic [REG_W:0] a_ext, b_ext, a_mag, b_mag;
    assign a_ext = {op_a_i[REG_W-1], op_a_i};
    assign b_ext = {op_b_i[REG_W-1], op_b_i};
    assign a_mag = a_ext[REG_W] ? (~a_ext + (REG_W+1)'(1)) : a_ext;
    assign b_mag = b_ext[REG_W] ? (~b_ext + (REG_W+1)'(1)) : b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !cancel_i) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        sign_q   <= op_a_i[REG_W-1] ^ op_b_i[REG_W-1];
                        acc_q    <= '0;
                        mcand_q  <= MUL_W'(a_mag);
                        mplier_q <= b_mag;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (cancel_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (cancel_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (sign_q) begin
                            acc_q <= ~acc_q + MUL_W'(1);
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= acc_q;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register driving the register-file write port,
// plus the iterative multiplier that feeds HI/LO.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 mem_RegWr,
    input  logic [REG_IDX_W-1:0] mem_rw,
    input  logic                 mem_MemtoReg,
    input  logic [REG_W-1:0]     mem_alu_out,
    input  logic [REG_W-1:0]     mem_rdata,
    input  logic                 mem_LB,
    input  logic                 mem_LBU,
    input  logic                 ex_mult_start,
    input  logic [REG_W-1:0]     ex_op_a,
    input  logic [REG_W-1:0]     ex_op_b,
    input  logic                 mult_cancel,
    output logic [REG_W-1:0]     busW,
    output logic [REG_IDX_W-1:0] rw,
    output logic                 RegWr,
    output logic                 LB,
    output logic                 LBU,
    output logic [REG_W-1:0]     Addr,
    output logic                 mult,
    output logic [MUL_W-1:0]     mult_result,
    output logic                 mult_busy
);

    memwb_t memwb_d, memwb_q;

    // Flush only clears the enables; the data fields are don't-care and simply hold.
    always_comb begin
        memwb_d = memwb_q;
        if (flush) begin
            memwb_d.regwr = 1'b0;
            memwb_d.lb    = 1'b0;
            memwb_d.lbu   = 1'b0;
        end else if (!stall) begin
            memwb_d.regwr = mem_valid & mem_RegWr & (mem_rw != '0);
            memwb_d.rw    = mem_rw;
            memwb_d.busw  = mem_MemtoReg ? mem_rdata : mem_alu_out;
            memwb_d.lb    = mem_valid & mem_LB;
            memwb_d.lbu   = mem_valid & mem_LBU;
            memwb_d.addr  = mem_alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    assign busW  = memwb_q.busw;
    assign rw    = memwb_q.rw;
    assign RegWr = memwb_q.regwr;
    assign LB    = memwb_q.lb;
    assign LBU   = memwb_q.lbu;
    assign Addr  = memwb_q.addr;

    seq_multiplier #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (ex_mult_start),
        .cancel_i (mult_cancel),
        .op_a_i   (ex_op_a),
        .op_b_i   (ex_op_b),
        .busy_o   (mult_busy),
        .done_o   (mult),
        .result_o (mult_result)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// checked against a formula-level reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, flush, mem_valid, mem_RegWr, mem_MemtoReg, mem_LB, mem_LBU;
    logic [4:0]  mem_rw;
    logic [31:0] mem_alu_out, mem_rdata, ex_op_a, ex_op_b;
    logic        ex_mult_start, mult_cancel;
    logic [31:0] busW, Addr;
    logic [4:0]  rw;
    logic        RegWr, LB, LBU, mult, mult_busy;
    logic [63:0] mult_result;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_result = '0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_RegWr(mem_RegWr), .mem_rw(mem_rw),
        .mem_MemtoReg(mem_MemtoReg), .mem_alu_out(mem_alu_out), .mem_rdata(mem_rdata),
        .mem_LB(mem_LB), .mem_LBU(mem_LBU),
        .ex_mult_start(ex_mult_start), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .mult_cancel(mult_cancel),
        .busW(busW), .rw(rw), .RegWr(RegWr), .LB(LB), .LBU(LBU), .Addr(Addr),
        .mult(mult), .mult_result(mult_result), .mult_busy(mult_busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stall = 0; flush = 0; mem_valid = 0; mem_RegWr = 0; mem_rw = '0;
        mem_MemtoReg = 0; mem_alu_out = '0; mem_rdata = '0; mem_LB = 0; mem_LBU = 0;
        ex_mult_start = 0; ex_op_a = '0; ex_op_b = '0; mult_cancel = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        step();
        step();
        checks++;
        if ({busW, rw, RegWr, LB, LBU, Addr, mult, mult_result} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busW=%h rw=%0d RegWr=%b LB=%b LBU=%b Addr=%h mult=%b res=%h want all 0",
                     busW, rw, RegWr, LB, LBU, Addr, mult, mult_result);
        end
        checks++;
        if (mult_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b want=0", mult_busy);
        end
        rst = 0;
        last_result = '0;
    endtask

    task automatic test_alu_write;
        mem_valid = 1; mem_RegWr = 1; mem_rw = 5'd8; mem_alu_out = 32'h1234;
        mem_MemtoReg = 0; mem_rdata = 32'hDEAD_BEEF;
        step();
        checks++;
        if ({RegWr, rw, busW} !== {1'b1, 5'd8, 32'h1234}) begin
            errors++;
            $display("FAIL alu_write got RegWr=%b rw=%0d busW=%h want 1/8/00001234", RegWr, rw, busW);
        end
        mem_rw = 5'd0;
        step();
        checks++;
        if ({RegWr, busW} !== {1'b0, 32'h1234}) begin
            errors++;
            $display("FAIL r0_suppress got RegWr=%b busW=%h want 0/00001234", RegWr, busW);
        end
        idle_inputs();
    endtask

    task automatic test_load_stall_flush;
        mem_valid = 1; mem_RegWr = 1; mem_rw = 5'd3; mem_MemtoReg = 1;
        mem_rdata = 32'h80FF_0011; mem_alu_out = 32'h101; mem_LB = 1;
        step();
        checks++;
        if ({LB, LBU, RegWr, Addr, busW} !== {1'b1, 1'b0, 1'b1, 32'h101, 32'h80FF_0011}) begin
            errors++;
            $display("FAIL load_lb got LB=%b LBU=%b RegWr=%b Addr=%h busW=%h want 1/0/1/00000101/80ff0011",
                     LB, LBU, RegWr, Addr, busW);
        end
        mem_LB = 0; mem_LBU = 1; mem_rw = 5'd17; mem_alu_out = 32'hCAFE; mem_rdata = 32'h5555;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({LB, LBU, RegWr, rw, Addr, busW} !== {1'b1, 1'b0, 1'b1, 5'd3, 32'h101, 32'h80FF_0011}) begin
                errors++;
                $display("FAIL stall_hold%0d got LB=%b LBU=%b RegWr=%b rw=%0d Addr=%h busW=%h want held load",
                         i, LB, LBU, RegWr, rw, Addr, busW);
            end
        end
        stall = 1; flush = 1;
        step();
        checks++;
        if ({RegWr, LB, LBU} !== 3'b000) begin
            errors++;
            $display("FAIL flush got RegWr=%b LB=%b LBU=%b want 0/0/0", RegWr, LB, LBU);
        end
        idle_inputs();
    endtask

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input string name);
        int n;
        int busy_n;
        bit seen;
        ex_op_a = a; ex_op_b = b; ex_mult_start = 1;
        step();
        ex_mult_start = 0;
        n = 0; busy_n = 0; seen = 0;
        if (mult_busy === 1'b1) busy_n++;
        while (!seen && n < 100) begin
            step();
            n++;
            if (mult === 1'b1) seen = 1;
            else if (mult_busy === 1'b1) busy_n++;
        end
        checks++;
        if (!seen || n != 34) begin
            errors++; $display("FAIL %s_latency got seen=%0d edge=%0d want edge 34", name, seen, n);
        end
        checks++;
        if (busy_n != 34) begin
            errors++; $display("FAIL %s_busy_cycles got=%0d want=34", name, busy_n);
        end
        checks++;
        if (mult_result !== exp) begin
            errors++; $display("FAIL %s_result got=%h want=%h", name, mult_result, exp);
        end
        step();
        checks++;
        if ({mult, mult_busy, mult_result} !== {1'b0, 1'b0, exp}) begin
            errors++;
            $display("FAIL %s_after got mult=%b busy=%b res=%h want 0/0/%h", name, mult, mult_busy, mult_result, exp);
        end
        last_result = exp;
    endtask

    task automatic test_mult_directed;
        run_mult(32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "m3x7");
        run_mult(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_sq");
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, "neg1_sq");
    endtask

    task automatic test_mult_random;
        logic [31:0] a, b;
        longint pa, pb;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            run_mult(a, b, 64'(pa * pb), "rand");
        end
    endtask

    task automatic test_cancel;
        int pulses;
        logic [31:0] a, b;
        longint pa, pb;
        ex_op_a = 32'd1234; ex_op_b = 32'd5678; ex_mult_start = 1;
        step();
        ex_mult_start = 0;
        for (int i = 0; i < 9; i++) step();
        mult_cancel = 1;
        step();
        mult_cancel = 0;
        checks++;
        if (mult_busy !== 1'b0) begin
            errors++; $display("FAIL cancel_busy got=%b want=0", mult_busy);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mult === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || mult_result !== last_result) begin
            errors++;
            $display("FAIL cancel_nopulse got pulses=%0d res=%h want 0/%h", pulses, mult_result, last_result);
        end
        // Start and cancel together while idle: the start must be dropped.
        ex_mult_start = 1; mult_cancel = 1; ex_op_a = 32'd3; ex_op_b = 32'd3;
        step();
        ex_mult_start = 0; mult_cancel = 0;
        checks++;
        if (mult_busy !== 1'b0) begin
            errors++; $display("FAIL cancel_vs_start_busy got=%b want=0", mult_busy);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mult === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL cancel_vs_start_pulse got=%0d want=0", pulses);
        end
        // Cancel at step 10 again, then restart right away.
        ex_op_a = 32'd99; ex_op_b = 32'd99; ex_mult_start = 1;
        step();
        ex_mult_start = 0;
        for (int i = 0; i < 9; i++) step();
        mult_cancel = 1;
        step();
        mult_cancel = 0;
        a = $urandom; b = $urandom;
        pa = longint'($signed(a)); pb = longint'($signed(b));
        run_mult(a, b, 64'(pa * pb), "restart");
    endtask

    task automatic test_rst_mid_run;
        int pulses;
        ex_op_a = 32'd77; ex_op_b = 32'd11; ex_mult_start = 1;
        step();
        ex_mult_start = 0;
        for (int i = 0; i < 15; i++) step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if ({mult_busy, mult, mult_result} !== '0) begin
            errors++;
            $display("FAIL rst_mid_run got busy=%b mult=%b res=%h want all 0", mult_busy, mult, mult_result);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mult === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL rst_mid_run_pulse got=%0d want=0", pulses);
        end
        last_result = '0;
    endtask

    task automatic test_concurrent;
        ex_op_a = 32'd5; ex_op_b = 32'hFFFF_FFFA; ex_mult_start = 1;
        step();
        ex_mult_start = 0;
        for (int i = 0; i < 33; i++) step();
        mem_valid = 1; mem_RegWr = 1; mem_rw = 5'd9; mem_alu_out = 32'h55;
        step();
        checks++;
        if ({mult, mult_result, RegWr, rw, busW} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFE2, 1'b1, 5'd9, 32'h55}) begin
            errors++;
            $display("FAIL concurrent got mult=%b res=%h RegWr=%b rw=%0d busW=%h want 1/ffffffffffffffe2/1/9/00000055",
                     mult, mult_result, RegWr, rw, busW);
        end
        idle_inputs();
        step();
        last_result = 64'hFFFF_FFFF_FFFF_FFE2;
    endtask

    task automatic test_wb_random;
        logic        e_regwr, e_lb, e_lbu;
        logic [4:0]  e_rw;
        logic [31:0] e_busw, e_addr;
        bit          data_known;
        data_known = 0;
        e_regwr = 0; e_lb = 0; e_lbu = 0; e_rw = '0; e_busw = '0; e_addr = '0;
        for (int i = 0; i < 300; i++) begin
            mem_valid    = ($urandom_range(0, 3) != 0);
            mem_RegWr    = ($urandom_range(0, 3) != 0);
            mem_rw       = 5'($urandom_range(0, 31));
            mem_MemtoReg = 1'($urandom_range(0, 1));
            mem_alu_out  = $urandom;
            mem_rdata    = $urandom;
            mem_LB       = ($urandom_range(0, 3) == 0);
            mem_LBU      = ($urandom_range(0, 3) == 0);
            stall        = (i != 0) && ($urandom_range(0, 4) == 0);
            flush        = (i != 0) && ($urandom_range(0, 6) == 0);
            if (flush) begin
                e_regwr = 0; e_lb = 0; e_lbu = 0;
            end else if (!stall) begin
                e_regwr = mem_valid && mem_RegWr && (mem_rw != 0);
                e_rw    = mem_rw;
                e_busw  = mem_MemtoReg ? mem_rdata : mem_alu_out;
                e_lb    = mem_valid && mem_LB;
                e_lbu   = mem_valid && mem_LBU;
                e_addr  = mem_alu_out;
                data_known = 1;
            end
            step();
            checks++;
            if ({RegWr, LB, LBU} !== {e_regwr, e_lb, e_lbu}) begin
                errors++;
                $display("FAIL wb_rand_ctl[%0d] got RegWr=%b LB=%b LBU=%b want %b/%b/%b",
                         i, RegWr, LB, LBU, e_regwr, e_lb, e_lbu);
            end
            if (data_known) begin
                checks++;
                if ({rw, busW, Addr} !== {e_rw, e_busw, e_addr}) begin
                    errors++;
                    $display("FAIL wb_rand_data[%0d] got rw=%0d busW=%h Addr=%h want %0d/%h/%h",
                             i, rw, busW, Addr, e_rw, e_busw, e_addr);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load_stall_flush();
        test_mult_directed();
        test_mult_random();
        test_cancel();
        test_concurrent();
        test_rst_mid_run();
        test_wb_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
